// File: rtl/cpu_pkg.sv
// cpu_pkg: shared constants and types for the fetch stage
package cpu_pkg;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    typedef enum logic {RUN, HALT} fetch_state_t;
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: fetch-stage control, ROM and IF/ID signals
interface fetch_stage_if #(parameter int ROM_AW = 14);
    logic              stall_f;
    logic              stall_d;
    logic              flush_d;
    logic              pc_src_d;
    logic [31:0]       pc_redirect_d;
    logic [ROM_AW-1:0] rom_addr;
    logic [31:0]       rom_instr;
    logic [31:0]       pc_f;
    logic [31:0]       instr_d;
    logic [31:0]       pcplus4_d;
    logic              valid_d;
    logic              fetch_err;
    modport master (
        output stall_f, stall_d, flush_d, pc_src_d, pc_redirect_d, rom_instr,
        input  rom_addr, pc_f, instr_d, pcplus4_d, valid_d, fetch_err
    );
    modport slave (
        input  stall_f, stall_d, flush_d, pc_src_d, pc_redirect_d, rom_instr,
        output rom_addr, pc_f, instr_d, pcplus4_d, valid_d, fetch_err
    );
endinterface

// File: rtl/fetch_stage_flopenrc.sv
// flopenrc: register with async active-low reset, enable and enable-qualified sync clear
module flopenrc #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    // load d (or zero when clearing) only while enabled
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) q <= RST_VAL;
        else if (en) q <= clr ? '0 : d;
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC register, next-PC select, ROM addressing and IF/ID register with halt FSM
module fetch_stage import cpu_pkg::*; #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          ROM_AW   = 14
) (
    input logic         clk,
    input logic         reset_n,
    fetch_stage_if.slave bus
);
    fetch_state_t state, state_next;
    logic [31:0]  pc_plus4, pc_next;
    logic         in_range, misaligned, pc_en, ifid_clr;
    logic [64:0]  ifid_q;

    assign in_range   = bus.pc_f[31:ROM_AW+2] == RESET_PC[31:ROM_AW+2];
    assign misaligned = bus.pc_src_d && !bus.stall_f && bus.pc_redirect_d[1:0] != 2'b00;
    assign pc_plus4   = bus.pc_f + 32'd4;
    assign pc_next    = bus.pc_src_d ? bus.pc_redirect_d : pc_plus4;
    assign bus.rom_addr = bus.pc_f[ROM_AW+1:2];

    // state register: HALT is only left through reset
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) state <= RUN;
        else state <= state_next;

    // halt on a misaligned redirect or a PC outside the ROM window
    always_comb
        state_next = (state == RUN && (misaligned || !in_range)) ? HALT : state;

    // PC advances only in RUN with a legal PC and target; IF/ID gets bubbles otherwise
    always_comb begin
        pc_en         = state == RUN && !bus.stall_f && !misaligned && in_range;
        ifid_clr      = bus.flush_d || state == HALT || !in_range;
        bus.fetch_err = state == HALT;
    end

    flopenrc #(.WIDTH(32), .RST_VAL(RESET_PC)) pc_reg (
        .clk(clk), .reset_n(reset_n), .en(pc_en), .clr(1'b0), .d(pc_next), .q(bus.pc_f)
    );

    flopenrc #(.WIDTH(65), .RST_VAL({NOP_INSTR, 32'h0, 1'b0})) ifid_reg (
        .clk(clk), .reset_n(reset_n), .en(!bus.stall_d), .clr(ifid_clr),
        .d({bus.rom_instr, pc_plus4, 1'b1}), .q(ifid_q)
    );

    assign {bus.instr_d, bus.pcplus4_d, bus.valid_d} = ifid_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage
module tb_fetch_stage;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int checks = 0;
    int errors = 0;
    exp_t q[$];

    fetch_stage_if #(.ROM_AW(14)) bus ();

    fetch_stage #(.RESET_PC(32'h0040_0000), .ROM_AW(14)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [13:0] a);
        return a == 14'd0 ? 32'h1111_1111 :
               a == 14'd1 ? 32'h2222_2222 :
               a == 14'd2 ? 32'h3333_3333 : {18'h2A5A5, a};
    endfunction

    assign bus.rom_instr = rom_word(bus.rom_addr);

    // scoreboard: each pending expectation is compared one cycle after it was pushed
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({bus.instr_d, bus.pcplus4_d, bus.valid_d} !== e) begin
                errors++;
                $display("FAIL ifid: got instr=%h pc4=%h valid=%b, expected instr=%h pc4=%h valid=%b",
                         bus.instr_d, bus.pcplus4_d, bus.valid_d, e.instr, e.pc4, e.valid);
            end
        end
    end

    task automatic push(input logic [31:0] instr, input logic [31:0] pc4, input logic valid);
        q.push_back({instr, pc4, valid});
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic sf, input logic sd, input logic fl, input logic src,
                         input logic [31:0] tgt);
        bus.stall_f = sf;
        bus.stall_d = sd;
        bus.flush_d = fl;
        bus.pc_src_d = src;
        bus.pc_redirect_d = tgt;
    endtask

    task automatic check_pc(input string name, input logic [31:0] exp_pc, input logic exp_err);
        checks++;
        if (bus.pc_f !== exp_pc || bus.fetch_err !== exp_err) begin
            errors++;
            $display("FAIL %s: got pc_f=%h fetch_err=%b, expected pc_f=%h fetch_err=%b",
                     name, bus.pc_f, bus.fetch_err, exp_pc, exp_err);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (bus.pc_f !== 32'h0040_0000 || bus.instr_d !== 32'h0 || bus.pcplus4_d !== 32'h0 ||
            bus.valid_d !== 1'b0 || bus.fetch_err !== 1'b0 || bus.rom_addr !== 14'h0) begin
            errors++;
            $display("FAIL %s: got pc=%h instr=%h pc4=%h valid=%b err=%b addr=%h, expected reset values",
                     name, bus.pc_f, bus.instr_d, bus.pcplus4_d, bus.valid_d, bus.fetch_err, bus.rom_addr);
        end
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("reset");
        reset_n = 1'b1;
    endtask

    task automatic test_sequential();
        push(32'h1111_1111, 32'h0040_0004, 1); tick(); check_pc("seq_pc1", 32'h0040_0004, 0);
        push(32'h2222_2222, 32'h0040_0008, 1); tick(); check_pc("seq_pc2", 32'h0040_0008, 0);
        push(32'h3333_3333, 32'h0040_000C, 1); tick(); check_pc("seq_pc3", 32'h0040_000C, 0);
    endtask

    task automatic test_stall();
        drive(1, 1, 0, 1, 32'h0040_0080);
        push(32'h3333_3333, 32'h0040_000C, 1); tick(); check_pc("stall_pc1", 32'h0040_000C, 0);
        push(32'h3333_3333, 32'h0040_000C, 1); tick(); check_pc("stall_pc2", 32'h0040_000C, 0);
        drive(0, 0, 0, 0, 32'h0);
        push({18'h2A5A5, 14'd3}, 32'h0040_0010, 1); tick(); check_pc("stall_resume", 32'h0040_0010, 0);
    endtask

    task automatic test_redirect();
        drive(0, 0, 1, 1, 32'h0040_0040);
        push(32'h0, 32'h0, 0); tick(); check_pc("redir_pc", 32'h0040_0040, 0);
        drive(0, 0, 0, 0, 32'h0);
        push({18'h2A5A5, 14'd16}, 32'h0040_0044, 1); tick(); check_pc("redir_next", 32'h0040_0044, 0);
    endtask

    task automatic test_stall_flush();
        drive(0, 1, 1, 0, 32'h0);
        push({18'h2A5A5, 14'd16}, 32'h0040_0044, 1); tick(); check_pc("sf_pc1", 32'h0040_0048, 0);
        drive(0, 0, 1, 0, 32'h0);
        push(32'h0, 32'h0, 0); tick(); check_pc("sf_pc2", 32'h0040_004C, 0);
    endtask

    task automatic test_window_end();
        drive(0, 0, 1, 1, 32'h0040_FFFC);
        push(32'h0, 32'h0, 0); tick(); check_pc("win_pc", 32'h0040_FFFC, 0);
        checks++;
        if (bus.rom_addr !== 14'h3FFF) begin
            errors++;
            $display("FAIL win_addr: got %h expected 3fff", bus.rom_addr);
        end
        drive(0, 0, 0, 0, 32'h0);
        push({18'h2A5A5, 14'h3FFF}, 32'h0041_0000, 1); tick(); check_pc("win_last", 32'h0041_0000, 0);
        push(32'h0, 32'h0, 0); tick(); check_pc("win_halt", 32'h0041_0000, 1);
        push(32'h0, 32'h0, 0); tick(); check_pc("win_frozen", 32'h0041_0000, 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("win_async_reset");
        #2;
        reset_n = 1'b1;
    endtask

    task automatic test_misaligned();
        push(32'h1111_1111, 32'h0040_0004, 1); tick(); check_pc("mis_pre", 32'h0040_0004, 0);
        drive(0, 0, 0, 1, 32'h0040_0042);
        push(32'h2222_2222, 32'h0040_0008, 1); tick(); check_pc("mis_halt", 32'h0040_0004, 1);
        drive(0, 0, 0, 0, 32'h0);
        push(32'h0, 32'h0, 0); tick(); check_pc("mis_bubble1", 32'h0040_0004, 1);
        drive(0, 0, 0, 1, 32'h0040_0100);
        push(32'h0, 32'h0, 0); tick(); check_pc("mis_bubble2", 32'h0040_0004, 1);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("mis_async_reset");
        drive(0, 0, 0, 0, 32'h0);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_stall_flush();
        test_window_end();
        test_misaligned();
        tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
